// File: rtl/run_det_pkg.sv
// run_det_pkg: shared state encoding and width helpers for the run detector
package run_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ONES  = 2'd1,
        S_ZEROS = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width able to hold the longer of the two run lengths, never below 1
    function automatic int rcw(input int a, input int b);
        int w;
        w = clog2((a > b ? a : b) + 1);
        return w < 1 ? 1 : w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at the maximum instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of ONES_LEN 1s and ZEROS_LEN 0s on a qualified serial stream
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int  ONES_LEN  = 3,
    parameter int  ZEROS_LEN = 2,
    parameter int  OVERLAP   = 1,
    parameter int  MCW       = 8,
    localparam int RCW       = rcw(ONES_LEN, ZEROS_LEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           x,
    output logic           z,
    output logic           z_ones,
    output logic           z_zeros,
    output logic [RCW-1:0] run_len,
    output logic           run_pol,
    output logic [MCW-1:0] match_cnt
);

    localparam logic [RCW:0] L1   = (RCW + 1)'(ONES_LEN);
    localparam logic [RCW:0] L0   = (RCW + 1)'(ZEROS_LEN);
    localparam logic [RCW:0] RMAX = (RCW + 1)'((1 << RCW) - 1);

    if (ONES_LEN < 0 || ONES_LEN >= 65536 || ZEROS_LEN < 0 || ZEROS_LEN >= 65536 || MCW < 1) begin : g_bad_params
        $error("run_length_detector: illegal parameter values");
    end

    state_t         state;
    logic           same;
    logic           hit;
    logic [RCW:0]   len;
    logic [RCW:0]   n;
    logic [RCW:0]   cap;
    logic [RCW:0]   nsat;
    logic [RCW-1:0] nxt;

    // Next run length for the incoming bit, its saturation cap and the hit decision
    always_comb begin
        same = x ? (state == S_ONES) : (state == S_ZEROS);
        len  = x ? L1 : L0;
        n    = same ? {1'b0, run_len} + (RCW + 1)'(1) : (RCW + 1)'(1);
        cap  = (len == '0) ? RMAX : len;
        nsat = (n > cap) ? cap : n;
        hit  = (len != '0) && ((OVERLAP != 0) ? (n >= len) : (n == len));
        nxt  = (OVERLAP == 0 && hit) ? '0 : nsat[RCW-1:0];
    end

    // Polarity state, run length and registered one-cycle hit pulses
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= S_IDLE;
            run_len <= '0;
            z       <= 1'b0;
            z_ones  <= 1'b0;
            z_zeros <= 1'b0;
        end else begin
            z       <= en && hit;
            z_ones  <= en && hit && x;
            z_zeros <= en && hit && !x;
            if (en) begin
                state   <= x ? S_ONES : S_ZEROS;
                run_len <= nxt;
            end
        end
    end

    assign run_pol = (state == S_ONES);

    sat_counter #(.W(MCW)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (en && hit),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: directed checks of overlap, non-overlap and narrow-counter variants
module tb_run_length_detector;

    logic clk = 1'b0;
    logic rst = 1'b0, clr = 1'b0, en = 1'b0, x = 1'b0;

    logic       z0, zo0, zz0, rp0;
    logic [1:0] rl0;
    logic [7:0] mc0;
    logic       z1, zo1, zz1, rp1;
    logic [1:0] rl1;
    logic [7:0] mc1;
    logic       z2, zo2, zz2, rp2;
    logic [1:0] rl2;
    logic [1:0] mc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    run_length_detector d0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x),
        .z(z0), .z_ones(zo0), .z_zeros(zz0), .run_len(rl0), .run_pol(rp0), .match_cnt(mc0)
    );

    run_length_detector #(.OVERLAP(0)) d1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x),
        .z(z1), .z_ones(zo1), .z_zeros(zz1), .run_len(rl1), .run_pol(rp1), .match_cnt(mc1)
    );

    run_length_detector #(.MCW(2)) d2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x),
        .z(z2), .z_ones(zo2), .z_zeros(zz2), .run_len(rl2), .run_pol(rp2), .match_cnt(mc2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge, then settle before sampling
    task automatic cyc(input logic r, input logic c, input logic e, input logic b);
        @(negedge clk);
        rst = r; clr = c; en = e; x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [6:0] t3_x;
        logic [6:0] t3_z;
        logic [4:0] t4_en;
        logic [4:0] t4_x;
        logic [4:0] t4_z;
        int         t4_rl [5];
        int         t1_rl [5];
        int         t2_rl [6];
        int         t5_mc [8];
        t1_rl = '{1, 2, 3, 3, 3};
        t2_rl = '{1, 2, 0, 1, 2, 0};
        t3_x  = 7'b1001000;
        t3_z  = 7'b0010011;
        t4_en = 5'b11001;
        t4_x  = 5'b11001;
        t4_z  = 5'b00001;
        t4_rl = '{1, 2, 2, 2, 3};
        t5_mc = '{0, 0, 1, 2, 3, 3, 3, 3};

        // Reset state
        do_reset();
        chk("rst_z", z0, 0);
        chk("rst_zo", zo0, 0);
        chk("rst_zz", zz0, 0);
        chk("rst_rl", rl0, 0);
        chk("rst_pol", rp0, 0);
        chk("rst_mc", mc0, 0);

        // 1: overlapping ones run; 2: non-overlapping on the same stimulus
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            if (i < 5) begin
                chk($sformatf("t1_zo%0d", i), zo0, i >= 2);
                chk($sformatf("t1_rl%0d", i), rl0, t1_rl[i]);
            end
            chk($sformatf("t2_zo%0d", i), zo1, i == 2 || i == 5);
            chk($sformatf("t2_rl%0d", i), rl1, t2_rl[i]);
            chk($sformatf("t2_z%0d", i), z1, i == 2 || i == 5);
        end
        chk("t2_mc", mc1, 2);
        chk("t1_mc", mc0, 4);

        // 3: zeros runs with polarity changes
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b1, t3_x[6-i]);
            chk($sformatf("t3_zz%0d", i), zz0, t3_z[6-i]);
            chk($sformatf("t3_zo%0d", i), zo0, 0);
            chk($sformatf("t3_z%0d", i), z0, t3_z[6-i]);
            chk($sformatf("t3_pol%0d", i), rp0, t3_x[6-i]);
        end
        chk("t3_mc", mc0, 3);

        // 4: unqualified bits are ignored and the run holds across the gap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, t4_en[4-i], t4_x[4-i]);
            chk($sformatf("t4_zo%0d", i), zo0, t4_z[4-i]);
            chk($sformatf("t4_zz%0d", i), zz0, 0);
            chk($sformatf("t4_rl%0d", i), rl0, t4_rl[i]);
        end

        // 5: narrow counter saturates instead of wrapping
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("t5_mc%0d", i), mc2, t5_mc[i]);
        end
        chk("t5_mc_wide", mc0, 6);

        // 6a: reset mid-run discards the partial run
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        do_reset();
        chk("t6r_z", z0, 0);
        chk("t6r_rl", rl0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6r_z_after", z0, 0);
        chk("t6r_rl_after", rl0, 1);

        // 6b: clear mid-run, with a prior hit so the counter has something to zero
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6c_mc_before", mc0, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t6c_z", z0, 0);
        chk("t6c_rl", rl0, 0);
        chk("t6c_pol", rp0, 0);
        chk("t6c_mc", mc0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6c_z_after", z0, 0);
        chk("t6c_rl_after", rl0, 1);
        chk("t6c_mc_after", mc0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
Parametrised serial run detector. Watches a 1-bit stream `x` and flags a run of ONES_LEN consecutive 1s and a run of ZEROS_LEN consecutive 0s. It adds a bit-qualifier, overlapping or non-overlapping mode, per-polarity hit flags, a live run length and a saturating hit counter. It is the successor to the fixed 3-bit-state consecutive-bit FSM and sits in the lab serial-input exercises, driven from switches or a pattern source.

Parameters:
- ONES_LEN, 3, length of a 1s run that produces a hit; 0 disables 1s detection.
- ZEROS_LEN, 2, length of a 0s run that produces a hit; 0 disables 0s detection.
- OVERLAP, 1, 1 = hit on every qualifying bit once run ≥ LEN; 0 = hit every LEN bits, then the run counter restarts.
- MCW, 8, width of match_cnt.
- RCW, derived, clog2(max(ONES_LEN,ZEROS_LEN)+1), minimum 1; width of run_len.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of state, outputs and counter; lower priority than rst.
- en  in  1  bit qualifier; `x` is consumed only on edges where en=1.
- x  in  1  serial data bit.
- z  out  1  registered hit pulse, equal to z_ones | z_zeros.
- z_ones  out  1  registered hit pulse for the 1s run.
- z_zeros  out  1  registered hit pulse for the 0s run.
- run_len  out  RCW  current run length of the active polarity.
- run_pol  out  1  polarity of the current run (1 = ones); 0 in S_IDLE.
- match_cnt  out  MCW  saturating count of hits.

Behaviour:
- Reset (rst=1 at an edge):
  - state=S_IDLE; run_len=0, run_pol=0, z=z_ones=z_zeros=0, match_cnt=0.
  - The z registers are explicitly reset.
- clr=1 (with rst=0): same effect as reset; en and x are ignored that cycle.
- States:
  - S_IDLE: no bit consumed since reset or clear.
  - S_ONES: the last consumed bit was 1.
  - S_ZEROS: the last consumed bit was 0.
- Transitions, only on en=1 edges:
  - x=1 goes to S_ONES; x=0 goes to S_ZEROS.
  - en=0: state and run_len hold; all z outputs are 0 that cycle.
- Run count:
  - Same polarity as the current state: n = run_len+1, saturating at that polarity's LEN.
  - Polarity change, or from S_IDLE: n = 1.
- Hit for a polarity with LEN>0, evaluated with n:
  - OVERLAP=1: hit when n ≥ LEN; run_len stores n (saturated).
  - OVERLAP=0: hit when n == LEN; run_len stores 0 and the state keeps its polarity, so the next hit needs another LEN bits.
- Disabled polarity (LEN=0): never hits; run_len still tracks, saturating at 2^RCW−1.
- Latency: a hit caused by the bit sampled at edge k drives its z output high from edge k to edge k+1.
  - One-cycle pulse per hit.
  - z_ones and z_zeros are mutually exclusive.
- match_cnt: increments by 1 on each hit edge and saturates at 2^MCW−1 (no wrap).
- Reset or clear mid-run discards the partial run: the first bit afterwards starts a run with n=1.
- Elaboration checks: ONES_LEN and ZEROS_LEN must be < 2^16; MCW ≥ 1.

Decomposition:
- Shared package `run_det_pkg`:
  - state enum {S_IDLE, S_ONES, S_ZEROS}, 2-bit encoding.
  - clog2 function and RCW derivation helper.
- One natural sub-module: `sat_counter`, parametrised width, with inc/clr ports and saturate-at-max. Used for match_cnt and reusable for run_len. Everything else stays in the top module.

Test Plan:
1. Defaults. rst, then en=1 with x=1,1,1,1,1 → z_ones=0,0,1,1,1; run_len=1,2,3,3,3; match_cnt ends at 3.
2. OVERLAP=0, ONES_LEN=3. Six 1s → z_ones pulses after bits 3 and 6 only; run_len=1,2,0,1,2,0; match_cnt=2.
3. Defaults. x=1,0,0,1,0,0,0 → z_zeros after bits 3, 6, 7; z_ones never asserted; run_pol follows x; match_cnt=3.
4. Qualifier. Bits x=1,1 with en=1, then two cycles en=0 with x=0, then x=1 with en=1 → no output during the gap; z_ones after the fifth edge (third qualified bit); run_len holds at 2 across the gap.
5. MCW=2. Drive 6 hits (x=1 ×8, defaults) → match_cnt reads 1,2,3,3,3,3; no wrap to 0.
6. Reset and clear mid-run:
   - x=1,1, then rst for 1 cycle, then x=1 → no hit; z=0 and run_len=0 right after the reset; run_len=1 after the final bit.
   - Repeat with clr instead of rst → identical response, and match_cnt is zeroed.
